// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word when the FIFO is non-empty and sends it as a UART frame.
// Optional even-parity bit between data and stop when PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    shift;
  logic [WIDTH-1:0]    shift_nx;
  logic [BAUD_W-1:0]   baud;
  logic [IDX_W-1:0]    idx;
  logic                baud_last;
  logic                start_ok;
`ifdef PARITY_EN
  logic                par;
`endif

  always_comb begin
    shift_nx  = shift >> 1;
    baud_last = (baud == BAUD_LAST);
    start_ok  = en && !fifo_empty;
  end

  // tx, rd_en, busy and frame_done are set on the edge that enters the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      baud       <= '0;
      idx        <= '0;
      tx         <= 1'b1;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      baud       <= baud_last ? '0 : baud + BAUD_W'(1);
      case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (start_ok) begin
            state <= POP;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        POP: begin
          baud  <= '0;
          state <= LOAD;
        end
        LOAD: begin
          baud  <= '0;
          shift <= fifo_rdata;
          idx   <= '0;
`ifdef PARITY_EN
          par   <= ^fifo_rdata;
`endif
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (baud_last) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            shift <= shift_nx;
            if (idx == IDX_LAST) begin
`ifdef PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
              tx  <= shift_nx[0];
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (baud_last) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // frame_done is raised one edge early so it is high during the final STOP cycle.
          if (baud == BAUD_PRE) begin
            frame_done <= 1'b1;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
          end
          if (baud_last) begin
            if (start_ok) begin
              state <= POP;
              rd_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO feeds words, a line decoder checks frames against a scoreboard.
// Honours PARITY_EN the same way the design does.
module tb_fifo_uart_tx;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CPB   = 8;
  localparam int unsigned CNT_W = 2;
`ifdef PARITY_EN
  localparam int unsigned NB = WIDTH + 3;
`else
  localparam int unsigned NB = WIDTH + 2;
`endif
  localparam int unsigned PERIOD = NB * CPB + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             rd_en;
  logic             tx;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rd_en      (rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] mem [0:63];
  int pushed = 0;
  int popped = 0;
  int empty_pops = 0;
  logic [WIDTH-1:0] exp_q [$];
  int rd_times [$];
  int start_times [$];
  int frames = 0;
  int fd_pulses = 0;
  int t0, t1, base_rd, base_st, base_fr;

  assign fifo_empty = (pushed == popped);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      if (pushed == popped) empty_pops <= empty_pops + 1;
      else begin
        fifo_rdata <= mem[popped % 64];
        popped     <= popped + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_times.push_back(cyc);
    if (frame_done) fd_pulses = fd_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    mem[pushed % 64] = w;
    exp_q.push_back(w);
    pushed++;
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Samples every cycle of every bit; a level change inside a bit counts as a glitch.
  task automatic decode();
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] e;
    logic [NB-1:0]    bits;
    int               glitch;
    logic             abort;
    logic             fd_last;
    w = '0; bits = '0; glitch = 0; abort = 1'b0; fd_last = 1'b0;
    start_times.push_back(cyc);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst) begin
          abort = 1'b1;
          break;
        end
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) glitch++;
        if (b == NB - 1 && c == CPB - 1) fd_last = frame_done;
      end
      if (abort) break;
    end
    if (abort) return;
    frames++;
    for (int i = 0; i < WIDTH; i++) w[i] = bits[i+1];
    if (exp_q.size() == 0) chk("sb_size", exp_q.size(), 1);
    else begin
      e = exp_q.pop_front();
      chk("word", w, e);
`ifdef PARITY_EN
      chk("parity", bits[NB-2], ^e);
`endif
    end
    chk("glitch", glitch, 0);
    chk("stop", bits[NB-1], 1);
    chk("fd_last", fd_last, 1);
  endtask

  initial begin : mon
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx) decode();
      prev = tx;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frames", frames, n);
  endtask

  task automatic wait_start(input int n, input int budget);
    int k;
    k = 0;
    while (start_times.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_start", start_times.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_rd = rd_times.size();
    base_st = start_times.size();
    base_fr = frames;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    push(4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", frame_cnt, 0);
    end
    rst = 1'b0;
    t0  = cyc;
    wait_frames(1, PERIOD + 20);
    chk("lat_rd_en", q_at(rd_times, 0), t0 + 1);
    chk("lat_start", q_at(start_times, 0), t0 + 3);
    repeat (3) @(negedge clk);
    chk("a_cnt", frame_cnt, 1);
    chk("a_busy", busy, 0);
    chk("a_rd_cnt", rd_times.size(), 1);

    do_reset();
    push(4'h1); push(4'h2); push(4'h3);
    wait_frames(base_fr + 3, 3 * PERIOD + 50);
    repeat (4) @(negedge clk);
    chk("b2b_rd_cnt", rd_times.size() - base_rd, 3);
    for (int i = 1; i < 3; i++) begin
      chk("b2b_rd_gap", q_at(rd_times, base_rd + i) - q_at(rd_times, base_rd + i - 1), PERIOD);
      chk("b2b_st_gap", q_at(start_times, base_st + i) - q_at(start_times, base_st + i - 1), PERIOD);
    end
    chk("b2b_cnt", frame_cnt, 3);
    chk("b2b_busy", busy, 0);
    chk("b2b_empty", fifo_empty, 1);

    do_reset();
    push(4'h5); push(4'h6);
    wait_start(base_st + 1, 20);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_frames(base_fr + 1, PERIOD + 20);
    repeat (20) @(negedge clk);
    chk("en_frames", frames - base_fr, 1);
    chk("en_rd_cnt", rd_times.size() - base_rd, 1);
    chk("en_busy", busy, 0);
    en = 1'b1;
    t1 = cyc;
    wait_frames(base_fr + 2, PERIOD + 20);
    chk("en_resume", q_at(rd_times, base_rd + 1), t1 + 1);
    repeat (3) @(negedge clk);
    chk("en_cnt", frame_cnt, 2);

    do_reset();
    push(4'h6);
    wait_start(base_st + 1, 20);
    repeat (CPB + 3) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", busy, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    push(4'hC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_frames(base_fr + 1, PERIOD + 20);
    repeat (3) @(negedge clk);
    chk("abort_cnt", frame_cnt, 1);
    push(4'hF); push(4'h0); push(4'h9); push(4'h7);
    wait_frames(base_fr + 5, 4 * PERIOD + 50);
    repeat (4) @(negedge clk);
    chk("sat_cnt", frame_cnt, 3);
    chk("sat_busy", busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    chk("empty_pops", empty_pops, 0);
    chk("fd_pulses", fd_pulses, frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
